// File: rtl/pu_msp430_irq_pkg.sv
// pu_msp430_irq_pkg
// Shared definitions for the MSP430 interrupt scheduler:
//   - irq_state_e  : scheduler FSM states (IDLE, ARB, REQ, ACK)
//   - IRQ_NR_DEF   : default number of maskable request lines
//   - VEC_BASE_DEF : default vector address of line 0
//   - NMI_IDX_DEF  : NMI index for the default line count (NMI sits one
//                    above the highest maskable line)
//   - irq_vec_of() : vector address for a given winner index
package pu_msp430_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2,
    ACK  = 2'd3
  } irq_state_e;

  localparam int          IRQ_NR_DEF   = 14;
  localparam logic [15:0] VEC_BASE_DEF = 16'hFFE0;
  localparam logic [3:0]  NMI_IDX_DEF  = 4'd14;

  // Vectors are word addresses, two bytes apart; the sum wraps at 16 bits.
  function automatic logic [15:0] irq_vec_of(input logic [15:0] base,
                                             input logic [3:0]  num);
    return base + {11'd0, num, 1'b0};
  endfunction

endpackage

// File: rtl/pu_msp430_irq_prio_enc.sv
// pu_msp430_irq_prio_enc
// Combinational fixed-priority encoder.
// Ports:
//   nmi   in            : NMI candidate, beats every maskable line
//   pend  in  [IRQ_NR]  : maskable candidates, higher index wins
//   valid out           : at least one candidate present
//   idx   out [4]       : winner index, IRQ_NR for NMI, 0 when none
module pu_msp430_irq_prio_enc
  import pu_msp430_irq_pkg::*;
#(
  parameter int IRQ_NR = IRQ_NR_DEF
) (
  input  logic              nmi,
  input  logic [IRQ_NR-1:0] pend,
  output logic              valid,
  output logic [3:0]        idx
);

  always_comb begin
    valid = nmi | (|pend);
    idx   = 4'd0;
    // Ascending scan: the last (highest) set line overwrites lower ones.
    for (int i = 0; i < IRQ_NR; i++) begin
      if (pend[i]) idx = 4'(i);
    end
    if (nmi) idx = 4'(IRQ_NR);
  end

endmodule

// File: rtl/pu_msp430_irq_sched.sv
// pu_msp430_irq_sched
// Interrupt scheduler between the peripherals/SFR and the CPU frontend.
// Collects NMI and up to IRQ_NR maskable requests, picks one by fixed
// priority (NMI, then highest index), presents its vector to the frontend
// and pulses the acknowledge back to the served source.
//
// Ports:
//   mclk        in            : main clock
//   puc_rst     in            : synchronous active-high reset
//   irq         in  [IRQ_NR]  : maskable requests (already IE-gated), level
//   nmi_pnd     in            : NMI pending, level, not masked by gie
//   gie         in            : global interrupt enable
//   cpu_irq_ack in            : frontend accept pulse
//   cpu_irq_req out           : request to frontend
//   irq_vec     out [16]      : vector of latched winner (0 when idle)
//   irq_num     out [4]       : index of latched winner (IRQ_NR = NMI)
//   irq_acc     out [IRQ_NR]  : one-hot acknowledge to served line
//   nmi_acc     out           : acknowledge to SFR NMI logic
//   irq_busy    out           : scheduler not in IDLE
//
// Configuration macro: IRQ_PENDING_LATCH_EN
//   defined   : per-line pending flops capture pulse requests until served
//   undefined : requests are level-sensitive and must be held until acked
//
// Handshake: cpu_irq_req rises on entry to REQ and stays high with irq_vec /
// irq_num frozen until either cpu_irq_ack is sampled high (-> ACK, ack wins
// over a simultaneous withdrawal) or the winner stops being a candidate
// (-> IDLE, request retracted). cpu_irq_ack is ignored outside REQ. All
// outputs come straight from flops.
module pu_msp430_irq_sched
  import pu_msp430_irq_pkg::*;
#(
  parameter int          IRQ_NR   = IRQ_NR_DEF,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic [IRQ_NR-1:0] irq,
  input  logic              nmi_pnd,
  input  logic              gie,
  input  logic              cpu_irq_ack,
  output logic              cpu_irq_req,
  output logic [15:0]       irq_vec,
  output logic [3:0]        irq_num,
  output logic [IRQ_NR-1:0] irq_acc,
  output logic              nmi_acc,
  output logic              irq_busy
);

  localparam logic [3:0] NMI_IDX = 4'(IRQ_NR);

  irq_state_e        state_q;
  irq_state_e        state_nxt;

  logic [IRQ_NR-1:0] pend;
  logic [IRQ_NR-1:0] cand_mask;
  logic              enc_valid;
  logic [3:0]        enc_idx;
  logic              winner_live;

  logic              req_nxt;
  logic [15:0]       vec_nxt;
  logic [3:0]        num_nxt;
  logic [IRQ_NR-1:0] acc_nxt;
  logic              nmi_acc_nxt;
  logic              busy_nxt;

  // ---------------------------------------------------------------------
  // Pending logic
  // ---------------------------------------------------------------------
`ifdef IRQ_PENDING_LATCH_EN
  logic [IRQ_NR-1:0] pend_q;

  // irq_acc is high exactly during the ACK cycle of the served line, so it
  // doubles as the clear; a request seen in that same cycle re-arms.
  always_ff @(posedge mclk) begin
    if (puc_rst) pend_q <= '0;
    else         pend_q <= irq | (pend_q & ~irq_acc);
  end

  // OR in the live line so latching adds no request latency.
  assign pend = pend_q | irq;
`else
  assign pend = irq;
`endif

  assign cand_mask = pend & {IRQ_NR{gie}};

  pu_msp430_irq_prio_enc #(
    .IRQ_NR (IRQ_NR)
  ) u_prio_enc (
    .nmi   (nmi_pnd),
    .pend  (cand_mask),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Is the frozen winner still a candidate? Loop select avoids indexing
  // pend with an out-of-range value when IRQ_NR < 16.
  always_comb begin
    winner_live = 1'b0;
    if (irq_num == NMI_IDX) begin
      winner_live = nmi_pnd;
    end else begin
      for (int i = 0; i < IRQ_NR; i++) begin
        if (irq_num == 4'(i)) winner_live = cand_mask[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (puc_rst) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (enc_valid) state_nxt = ARB;
      ARB:  state_nxt = enc_valid ? REQ : IDLE;
      REQ: begin
        if (cpu_irq_ack)       state_nxt = ACK;
        else if (!winner_live) state_nxt = IDLE;
      end
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (next values, registered below)
  // ---------------------------------------------------------------------
  always_comb begin
    req_nxt     = (state_nxt == REQ);
    busy_nxt    = (state_nxt != IDLE);
    vec_nxt     = irq_vec;
    num_nxt     = irq_num;
    acc_nxt     = '0;
    nmi_acc_nxt = 1'b0;

    if (state_nxt == IDLE) begin
      vec_nxt = 16'h0000;
      num_nxt = 4'd0;
    end else if (state_q == ARB) begin
      // Winner captured on the ARB -> REQ edge, then frozen through ACK.
      vec_nxt = irq_vec_of(VEC_BASE, enc_idx);
      num_nxt = enc_idx;
    end

    if (state_nxt == ACK) begin
      if (irq_num == NMI_IDX) begin
        nmi_acc_nxt = 1'b1;
      end else begin
        for (int i = 0; i < IRQ_NR; i++) begin
          if (irq_num == 4'(i)) acc_nxt[i] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      cpu_irq_req <= 1'b0;
      irq_vec     <= 16'h0000;
      irq_num     <= 4'd0;
      irq_acc     <= '0;
      nmi_acc     <= 1'b0;
      irq_busy    <= 1'b0;
    end else begin
      cpu_irq_req <= req_nxt;
      irq_vec     <= vec_nxt;
      irq_num     <= num_nxt;
      irq_acc     <= acc_nxt;
      nmi_acc     <= nmi_acc_nxt;
      irq_busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_pu_msp430_irq_sched.sv
// tb_pu_msp430_irq_sched
// Bench for pu_msp430_irq_sched (default parameters). Inputs change and
// outputs are sampled on the falling edge of mclk; the DUT acts on the
// rising edge. Expected {irq_num, irq_vec} pairs are queued when the
// request stimulus is driven and popped when the DUT raises cpu_irq_req.
module tb_pu_msp430_irq_sched;

  localparam int IRQ_NR = 14;

  // clock / reset
  logic mclk = 1'b0;
  logic puc_rst;
  always #5 mclk = ~mclk;

  logic [IRQ_NR-1:0] irq;
  logic              nmi_pnd;
  logic              gie;
  logic              cpu_irq_ack;
  logic              cpu_irq_req;
  logic [15:0]       irq_vec;
  logic [3:0]        irq_num;
  logic [IRQ_NR-1:0] irq_acc;
  logic              nmi_acc;
  logic              irq_busy;

  pu_msp430_irq_sched #(
    .IRQ_NR   (IRQ_NR),
    .VEC_BASE (16'hFFE0)
  ) dut (
    .mclk        (mclk),
    .puc_rst     (puc_rst),
    .irq         (irq),
    .nmi_pnd     (nmi_pnd),
    .gie         (gie),
    .cpu_irq_ack (cpu_irq_ack),
    .cpu_irq_req (cpu_irq_req),
    .irq_vec     (irq_vec),
    .irq_num     (irq_num),
    .irq_acc     (irq_acc),
    .nmi_acc     (nmi_acc),
    .irq_busy    (irq_busy)
  );

  // scoreboard: {irq_num, irq_vec}
  logic [19:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(negedge mclk);
  endtask

  function automatic logic [19:0] exp_entry(input int n);
    logic [15:0] v;
    v = 16'hFFE0 + 16'(2 * n);
    return {4'(n), v};
  endfunction

  // Wait for a request, check it against the queue head, ack it, check the
  // acknowledge pulse, then either release the source or re-pulse it.
  task automatic serve(input bit repulse);
    int          n;
    logic [19:0] e;
    logic [IRQ_NR-1:0] exp_acc;
    logic        exp_nmi;
    n = 0;
    while (cpu_irq_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (cpu_irq_req !== 1'b1) begin
      failures++;
      $display("FAIL serve_timeout cpu_irq_req=%b want 1", cpu_irq_req);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL serve_unexpected irq_num=%0d want no request", irq_num);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (irq_vec !== e[15:0]) begin
      failures++;
      $display("FAIL serve_vec irq_vec=%h want %h", irq_vec, e[15:0]);
    end
    checks++;
    if (irq_num !== e[19:16]) begin
      failures++;
      $display("FAIL serve_num irq_num=%0d want %0d", irq_num, e[19:16]);
    end
    cpu_irq_ack = 1'b1;
    tick();
    cpu_irq_ack = 1'b0;
    exp_nmi = (e[19:16] == 4'd14);
    exp_acc = exp_nmi ? '0 : (14'd1 << e[19:16]);
    checks++;
    if (irq_acc !== exp_acc || nmi_acc !== exp_nmi || cpu_irq_req !== 1'b0) begin
      failures++;
      $display("FAIL serve_ack irq_acc=%h nmi_acc=%b req=%b want %h %b 0",
               irq_acc, nmi_acc, cpu_irq_req, exp_acc, exp_nmi);
    end
    if (repulse) begin
      if (exp_nmi) nmi_pnd = 1'b1;
      else         irq[e[19:16]] = 1'b1;
    end else begin
      if (exp_nmi) nmi_pnd = 1'b0;
      else         irq[e[19:16]] = 1'b0;
    end
    tick();
    if (repulse && !exp_nmi) irq[e[19:16]] = 1'b0;
    checks++;
    if (irq_busy !== 1'b0 || irq_acc !== '0 || nmi_acc !== 1'b0 || irq_vec !== 16'h0) begin
      failures++;
      $display("FAIL serve_idle busy=%b acc=%h nmi_acc=%b vec=%h want 0 0 0 0",
               irq_busy, irq_acc, nmi_acc, irq_vec);
    end
  endtask

  task automatic test_reset();
    puc_rst = 1'b1;
    irq = '0; nmi_pnd = 1'b0; gie = 1'b0; cpu_irq_ack = 1'b0;
    tick(); tick();
    puc_rst = 1'b0;
    checks++;
    if ({cpu_irq_req, irq_vec, irq_num, irq_acc, nmi_acc, irq_busy} !== '0) begin
      failures++;
      $display("FAIL reset req=%b vec=%h num=%0d acc=%h nmi_acc=%b busy=%b want all 0",
               cpu_irq_req, irq_vec, irq_num, irq_acc, nmi_acc, irq_busy);
    end
  endtask

  task automatic test_basic();
    // cycle 0
    gie = 1'b1;
    irq[3] = 1'b1;
    exp_q.push_back(exp_entry(3));
    tick();  // cycle 1: ARB
    checks++;
    if (cpu_irq_req !== 1'b0 || irq_busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_arb req=%b busy=%b want 0 1", cpu_irq_req, irq_busy);
    end
    tick();  // cycle 2: REQ
    checks++;
    if (cpu_irq_req !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency req=%b want 1", cpu_irq_req);
    end
    tick(); tick();  // cycle 4
    serve(1'b0);     // ack at cycle 4, acc at 5, idle at 6
  endtask

  task automatic test_priority();
    irq[13] = 1'b1; irq[2] = 1'b1; nmi_pnd = 1'b1; gie = 1'b1;
    exp_q.push_back(exp_entry(14));
    exp_q.push_back(exp_entry(13));
    exp_q.push_back(exp_entry(2));
    serve(1'b0);
    serve(1'b0);
    serve(1'b0);
  endtask

  task automatic test_gie();
    gie = 1'b0;
    irq[5] = 1'b1;
    cpu_irq_ack = 1'b1;  // stray ack while idle must be ignored
    tick();
    cpu_irq_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (cpu_irq_req !== 1'b0 || irq_busy !== 1'b0 || irq_acc !== '0) begin
      failures++;
      $display("FAIL gie_masked req=%b busy=%b acc=%h want 0 0 0",
               cpu_irq_req, irq_busy, irq_acc);
    end
    nmi_pnd = 1'b1;
    exp_q.push_back(exp_entry(14));
    serve(1'b0);
    irq[5] = 1'b0;
    gie = 1'b1;
    tick();
  endtask

`ifndef IRQ_PENDING_LATCH_EN
  task automatic test_withdraw();
    irq[7] = 1'b1;
    tick(); tick();
    checks++;
    if (cpu_irq_req !== 1'b1 || irq_num !== 4'd7) begin
      failures++;
      $display("FAIL withdraw_req req=%b num=%0d want 1 7", cpu_irq_req, irq_num);
    end
    irq[7] = 1'b0;
    tick();
    checks++;
    if (cpu_irq_req !== 1'b0 || irq_acc !== '0) begin
      failures++;
      $display("FAIL withdraw_drop req=%b acc=%h want 0 0", cpu_irq_req, irq_acc);
    end
    tick();
    checks++;
    if (irq_acc !== '0 || irq_busy !== 1'b0) begin
      failures++;
      $display("FAIL withdraw_noack acc=%h busy=%b want 0 0", irq_acc, irq_busy);
    end
    // drop and ack together: ack wins
    irq[7] = 1'b1;
    tick(); tick();
    irq[7] = 1'b0;
    cpu_irq_ack = 1'b1;
    tick();
    cpu_irq_ack = 1'b0;
    checks++;
    if (irq_acc !== 14'h0080) begin
      failures++;
      $display("FAIL withdraw_ackwins irq_acc=%h want 0080", irq_acc);
    end
    tick();
  endtask
`else
  task automatic test_latch();
    irq[1] = 1'b1;
    tick();
    irq[1] = 1'b0;
    exp_q.push_back(exp_entry(1));
    exp_q.push_back(exp_entry(1));
    serve(1'b1);  // re-pulse in ACK cycle
    serve(1'b0);
    tick(); tick(); tick();
    checks++;
    if (irq_busy !== 1'b0) begin
      failures++;
      $display("FAIL latch_cleared busy=%b want 0", irq_busy);
    end
  endtask
`endif

  task automatic test_reset_in_req();
    irq[4] = 1'b1;
    tick(); tick();
    checks++;
    if (cpu_irq_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_req_setup req=%b want 1", cpu_irq_req);
    end
    puc_rst = 1'b1;
    cpu_irq_ack = 1'b1;
    tick();
    puc_rst = 1'b0;
    cpu_irq_ack = 1'b0;
    irq[4] = 1'b0;
    checks++;
    if ({cpu_irq_req, irq_vec, irq_num, irq_acc, nmi_acc, irq_busy} !== '0) begin
      failures++;
      $display("FAIL rst_in_req req=%b vec=%h num=%0d acc=%h nmi_acc=%b busy=%b want all 0",
               cpu_irq_req, irq_vec, irq_num, irq_acc, nmi_acc, irq_busy);
    end
    tick();
    checks++;
    if (irq_acc !== '0 || nmi_acc !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_ack acc=%h nmi_acc=%b want 0 0", irq_acc, nmi_acc);
    end
    irq[0] = 1'b1;
    exp_q.push_back(exp_entry(0));
    serve(1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 16; k++) begin
      n = $urandom_range(0, IRQ_NR);  // IRQ_NR selects NMI
      if (n == IRQ_NR) nmi_pnd = 1'b1;
      else             irq[n] = 1'b1;
      exp_q.push_back(exp_entry(n));
      serve(1'b0);
      for (int w = $urandom_range(0, 2); w > 0; w--) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_gie();
`ifndef IRQ_PENDING_LATCH_EN
    test_withdraw();
`else
    test_latch();
`endif
    test_reset_in_req();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover entries=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
